// File: rtl/audio_seq_pkg.sv
// ---------------------------------------------------------------------------
// audio_seq_pkg
// Shared definitions for the audio note sequencer: sequencer state encoding,
// the 16-bit pattern step word layout and a helper that turns the stored
// duration field into the last value of the duration counter.
//
// Step word layout:
//   [3:0]  note enables, bit0 = C, bit1 = D, bit2 = E, bit3 = F
//   [4]    drum hit at step start
//   [5]    piano octave
//   [6]    drum variation
//   [7]    end of pattern
//   [15:8] duration in step units (0 plays as 1 unit)
// ---------------------------------------------------------------------------
package audio_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_PLAY    = 2'd2,
        ST_RELEASE = 2'd3
    } seq_state_t;

    localparam int STEP_W       = 16;
    localparam int NOTE_LSB     = 0;
    localparam int NOTE_W       = 4;
    localparam int BIT_DRUM     = 4;
    localparam int BIT_OCTAVE   = 5;
    localparam int BIT_DRUM_VAR = 6;
    localparam int BIT_END      = 7;
    localparam int DUR_LSB      = 8;
    localparam int DUR_W        = 8;

    localparam logic [STEP_W-1:0] MASK_NOTES    = 16'h000F;
    localparam logic [STEP_W-1:0] MASK_DRUM     = 16'h0010;
    localparam logic [STEP_W-1:0] MASK_OCTAVE   = 16'h0020;
    localparam logic [STEP_W-1:0] MASK_DRUM_VAR = 16'h0040;
    localparam logic [STEP_W-1:0] MASK_END      = 16'h0080;
    localparam logic [STEP_W-1:0] MASK_DUR      = 16'hFF00;

    // A zero duration plays for one unit, so both 0 and 1 end on count 0.
    function automatic logic [DUR_W-1:0] dur_last(input logic [DUR_W-1:0] dur);
        return (dur == '0) ? '0 : dur - 1'b1;
    endfunction

endpackage

// File: rtl/drum_pulse_gen.sv
// ---------------------------------------------------------------------------
// drum_pulse_gen
// Produces the fixed-width run_drum pulse audio_core needs. A trigger starts
// a pulse of exactly DRUM_PULSE_CYC cycles; triggers arriving while the
// pulse is high are dropped, so the output always spends at least one cycle
// low between pulses. i_clear kills the pulse immediately (playback stop).
//
// Ports:
//   i_clk       clock
//   i_rst_n     asynchronous active-low reset
//   i_trigger   start request, honoured only while the pulse is low
//   i_clear     force the pulse low on the next edge, beats i_trigger
//   o_run_drum  pulse output (registered)
// ---------------------------------------------------------------------------
module drum_pulse_gen
    import audio_seq_pkg::*;
#(
    parameter int DRUM_PULSE_CYC = 20_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_trigger,
    input  logic i_clear,
    output logic o_run_drum
);

    localparam int CNT_W = (DRUM_PULSE_CYC > 1) ? $clog2(DRUM_PULSE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRUM_PULSE_CYC - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_run;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run <= 1'b0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_run <= 1'b0;
            r_cnt <= '0;
        end else if (r_run) begin
            // The edge that drops the pulse ignores any trigger, which
            // guarantees the low cycle before a following pulse.
            if (r_cnt == CNT_LAST) begin
                r_run <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (i_trigger) begin
            r_run <= 1'b1;
            r_cnt <= '0;
        end
    end

    assign o_run_drum = r_run;

endmodule

// File: rtl/audio_note_sequencer.sv
// ---------------------------------------------------------------------------
// audio_note_sequencer
// Step sequencer feeding audio_core from a writable STEPS x 16 pattern table.
// Each step is fetched (1 cycle), played for max(dur,1)*STEP_UNIT_CYC cycles,
// then released for NOTE_GAP_CYC cycles with all notes low so a repeated note
// re-triggers. Drum steps fire a DRUM_PULSE_CYC-wide run_drum pulse.
//
// Build option: define VOLUME_FADE_EN to make the volume output ramp by one
// every FADE_DIV_CYC cycles toward i_vol_target; otherwise the volume output
// is simply the target registered once.
//
// Ports:
//   i_clk100mhz        100 MHz clock
//   i_cpu_resetn       asynchronous active-low reset
//   i_wr_en/addr/data  pattern table write port (usable at any time)
//   i_start            1-cycle pulse, start playback at step 0 (ignored when busy)
//   i_stop             1-cycle pulse, abort playback (wins over i_start)
//   i_loop_en          wrap to step 0 at pattern end instead of finishing
//   i_vol_target       requested volume
//   o_note_c..o_note_f note enables to audio_core
//   o_run_drum         drum trigger pulse to audio_core
//   o_piano_octave     octave select to audio_core
//   o_drum_variation   drum variation select to audio_core
//   o_volume_ctrl      volume to audio_core
//   o_busy             high whenever the sequencer is not idle
//   o_step_idx         index of the current step
//   o_done             1-cycle pulse when a non-looping pattern completes
// ---------------------------------------------------------------------------
module audio_note_sequencer
    import audio_seq_pkg::*;
#(
    parameter int STEPS          = 16,
    parameter int STEP_UNIT_CYC  = 1_000_000,
    parameter int NOTE_GAP_CYC   = 500_000,
    parameter int DRUM_PULSE_CYC = 20_000,
`ifdef VOLUME_FADE_EN
    parameter int FADE_DIV_CYC   = 100_000,
`endif
    localparam int IDX_W = $clog2(STEPS)
) (
    input  logic             i_clk100mhz,
    input  logic             i_cpu_resetn,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_addr,
    input  logic [15:0]      i_wr_data,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_loop_en,
    input  logic [7:0]       i_vol_target,
    output logic             o_note_c,
    output logic             o_note_d,
    output logic             o_note_e,
    output logic             o_note_f,
    output logic             o_run_drum,
    output logic             o_piano_octave,
    output logic             o_drum_variation,
    output logic [7:0]       o_volume_ctrl,
    output logic             o_busy,
    output logic [IDX_W-1:0] o_step_idx,
    output logic             o_done
);

    localparam int UNIT_W = (STEP_UNIT_CYC > 1) ? $clog2(STEP_UNIT_CYC) : 1;
    localparam int GAP_W  = (NOTE_GAP_CYC > 1)  ? $clog2(NOTE_GAP_CYC)  : 1;
    localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(STEP_UNIT_CYC - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(NOTE_GAP_CYC - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(STEPS - 1);

    logic [STEP_W-1:0] r_table [STEPS];

    seq_state_t        r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [NOTE_W-1:0] r_notes;
    logic              r_octave;
    logic              r_drum_var;
    logic              r_busy;
    logic              r_done;
    logic [DUR_W-1:0]  r_dur_last;
    logic              r_end;
    logic [UNIT_W-1:0] r_unit_cnt;
    logic [DUR_W-1:0]  r_dur_cnt;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [7:0]        r_volume;

    logic [STEP_W-1:0] w_fetch_word;
    logic              w_drum_trig;
    logic              w_run_drum;

    // ------------------------------------------------------------------
    // Pattern table. Playback only reads it in FETCH, so rewriting the
    // step being played takes effect the next time that step is fetched.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk100mhz or negedge i_cpu_resetn) begin
        if (!i_cpu_resetn) begin
            for (int i = 0; i < STEPS; i++) begin
                r_table[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_table[i_wr_addr] <= i_wr_data;
        end
    end

    assign w_fetch_word = r_table[r_idx];

    // ------------------------------------------------------------------
    // Sequencer FSM: IDLE -> FETCH -> PLAY -> RELEASE -> FETCH | IDLE.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk100mhz or negedge i_cpu_resetn) begin
        if (!i_cpu_resetn) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_notes    <= '0;
            r_octave   <= 1'b0;
            r_drum_var <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dur_last <= '0;
            r_end      <= 1'b0;
            r_unit_cnt <= '0;
            r_dur_cnt  <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_stop) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_notes <= '0;
                r_idx   <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_start) begin
                            r_state <= ST_FETCH;
                            r_busy  <= 1'b1;
                        end
                    end
                    ST_FETCH: begin
                        // Outputs come straight from the table word here so
                        // the notes appear on the same edge the step latches.
                        r_notes    <= w_fetch_word[NOTE_LSB +: NOTE_W];
                        r_octave   <= w_fetch_word[BIT_OCTAVE];
                        r_drum_var <= w_fetch_word[BIT_DRUM_VAR];
                        r_dur_last <= dur_last(w_fetch_word[DUR_LSB +: DUR_W]);
                        r_end      <= w_fetch_word[BIT_END];
                        r_unit_cnt <= '0;
                        r_dur_cnt  <= '0;
                        r_state    <= ST_PLAY;
                    end
                    ST_PLAY: begin
                        if (r_unit_cnt == UNIT_LAST) begin
                            r_unit_cnt <= '0;
                            if (r_dur_cnt == r_dur_last) begin
                                r_notes   <= '0;
                                r_gap_cnt <= '0;
                                r_state   <= ST_RELEASE;
                            end else begin
                                r_dur_cnt <= r_dur_cnt + 1'b1;
                            end
                        end else begin
                            r_unit_cnt <= r_unit_cnt + 1'b1;
                        end
                    end
                    ST_RELEASE: begin
                        // Octave and drum variation keep their step values
                        // through the gap; only the notes are released.
                        if (r_gap_cnt == GAP_LAST) begin
                            if (r_end || (r_idx == IDX_LAST)) begin
                                r_idx <= '0;
                                if (i_loop_en) begin
                                    r_state <= ST_FETCH;
                                end else begin
                                    r_state <= ST_IDLE;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                end
                            end else begin
                                r_idx   <= r_idx + 1'b1;
                                r_state <= ST_FETCH;
                            end
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Drum request lines up with the FETCH->PLAY edge so run_drum rises
    // together with the step's notes.
    assign w_drum_trig = (r_state == ST_FETCH) && w_fetch_word[BIT_DRUM];

    drum_pulse_gen #(
        .DRUM_PULSE_CYC (DRUM_PULSE_CYC)
    ) u_drum_pulse_gen (
        .i_clk      (i_clk100mhz),
        .i_rst_n    (i_cpu_resetn),
        .i_trigger  (w_drum_trig),
        .i_clear    (i_stop),
        .o_run_drum (w_run_drum)
    );

    // ------------------------------------------------------------------
    // Volume
    // ------------------------------------------------------------------
`ifdef VOLUME_FADE_EN
    localparam int FADE_W = (FADE_DIV_CYC > 1) ? $clog2(FADE_DIV_CYC) : 1;
    localparam logic [FADE_W-1:0] FADE_LAST = FADE_W'(FADE_DIV_CYC - 1);

    logic [FADE_W-1:0] r_fade_cnt;

    // One step per fade period toward the live target; equality holds.
    always_ff @(posedge i_clk100mhz or negedge i_cpu_resetn) begin
        if (!i_cpu_resetn) begin
            r_fade_cnt <= '0;
            r_volume   <= '0;
        end else if (r_fade_cnt == FADE_LAST) begin
            r_fade_cnt <= '0;
            if (r_volume < i_vol_target) begin
                r_volume <= r_volume + 1'b1;
            end else if (r_volume > i_vol_target) begin
                r_volume <= r_volume - 1'b1;
            end
        end else begin
            r_fade_cnt <= r_fade_cnt + 1'b1;
        end
    end
`else
    always_ff @(posedge i_clk100mhz or negedge i_cpu_resetn) begin
        if (!i_cpu_resetn) begin
            r_volume <= '0;
        end else begin
            r_volume <= i_vol_target;
        end
    end
`endif

    assign o_note_c         = r_notes[0];
    assign o_note_d         = r_notes[1];
    assign o_note_e         = r_notes[2];
    assign o_note_f         = r_notes[3];
    assign o_run_drum       = w_run_drum;
    assign o_piano_octave   = r_octave;
    assign o_drum_variation = r_drum_var;
    assign o_volume_ctrl    = r_volume;
    assign o_busy           = r_busy;
    assign o_step_idx       = r_idx;
    assign o_done           = r_done;

endmodule

// File: tb/tb_audio_note_sequencer.sv
`timescale 1ns/1ps
module tb_audio_note_sequencer;

    localparam int STEPS   = 16;
    localparam int IDX_W   = 4;
    localparam int UNIT    = 10;
    localparam int GAP     = 2;
    localparam int DRUM_A  = 4;
    localparam int DRUM_B  = 15;
    // Between two steps the notes are low for the release gap plus the fetch cycle.
    localparam int LOW_GAP = GAP + 1;

    typedef struct { int val; int len; } seg_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wr_en = 1'b0, start = 1'b0, stop = 1'b0, loop_en = 1'b0;
    logic [IDX_W-1:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [7:0]  vol_target = '0;

    logic note_c, note_d, note_e, note_f, run_drum, octave, dvar, busy, done;
    logic [7:0] vol;
    logic [IDX_W-1:0] idx;
    logic note_c_b, note_d_b, note_e_b, note_f_b, run_drum_b, octave_b, dvar_b, busy_b, done_b;
    logic [7:0] vol_b;
    logic [IDX_W-1:0] idx_b;
    logic [3:0] notes;
    assign notes = {note_f, note_e, note_d, note_c};

    always #5 clk = ~clk;

    audio_note_sequencer #(.STEPS(STEPS), .STEP_UNIT_CYC(UNIT), .NOTE_GAP_CYC(GAP),
                           .DRUM_PULSE_CYC(DRUM_A)) u_dut (
        .i_clk100mhz(clk), .i_cpu_resetn(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .i_start(start), .i_stop(stop), .i_loop_en(loop_en),
        .i_vol_target(vol_target), .o_note_c(note_c), .o_note_d(note_d), .o_note_e(note_e),
        .o_note_f(note_f), .o_run_drum(run_drum), .o_piano_octave(octave),
        .o_drum_variation(dvar), .o_volume_ctrl(vol), .o_busy(busy), .o_step_idx(idx),
        .o_done(done));

    audio_note_sequencer #(.STEPS(STEPS), .STEP_UNIT_CYC(UNIT), .NOTE_GAP_CYC(GAP),
                           .DRUM_PULSE_CYC(DRUM_B)) u_dut_long_drum (
        .i_clk100mhz(clk), .i_cpu_resetn(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .i_start(start), .i_stop(stop), .i_loop_en(loop_en),
        .i_vol_target(vol_target), .o_note_c(note_c_b), .o_note_d(note_d_b), .o_note_e(note_e_b),
        .o_note_f(note_f_b), .o_run_drum(run_drum_b), .o_piano_octave(octave_b),
        .o_drum_variation(dvar_b), .o_volume_ctrl(vol_b), .o_busy(busy_b), .o_step_idx(idx_b),
        .o_done(done_b));

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Scoreboard queues
    seg_t exp_note[$];
    int   exp_gap[$];
    int   exp_drum_a[$];
    int   exp_drum_b[$];

    task automatic push_note(input int val, input int len);
        seg_t s;
        s.val = val;
        s.len = len;
        exp_note.push_back(s);
    endtask

    // Output monitor: measures note segments, inter-note gaps and drum pulses
    int cyc = 0, rise_cyc = 0, fall_cyc = 0, dr_a = 0, dr_b = 0, done_cnt = 0, done_cyc = 0;
    bit gap_valid = 1'b0;
    logic [3:0] pn = '0;
    logic pa = 1'b0, pb = 1'b0;

    always @(negedge clk) begin
        seg_t e;
        int g;
        cyc++;
        if (notes != pn) begin
            if (pn != 0) begin
                if (exp_note.size() == 0) chk("note_extra", exp_note.size(), 1);
                else begin
                    e = exp_note.pop_front();
                    chk("note_val", int'(pn), e.val);
                    chk("note_len", cyc - rise_cyc, e.len);
                end
                fall_cyc = cyc;
                gap_valid = 1'b1;
            end
            if (notes != 0) begin
                if (gap_valid) begin
                    if (exp_gap.size() == 0) chk("gap_extra", exp_gap.size(), 1);
                    else begin
                        g = exp_gap.pop_front();
                        chk("note_gap", cyc - fall_cyc, g);
                    end
                end
                rise_cyc = cyc;
            end
        end
        if (!busy && notes == 0) gap_valid = 1'b0;
        pn = notes;

        if (run_drum && !pa) dr_a = cyc;
        if (!run_drum && pa) begin
            if (exp_drum_a.size() == 0) chk("drum_extra", exp_drum_a.size(), 1);
            else begin
                g = exp_drum_a.pop_front();
                chk("drum_len", cyc - dr_a, g);
            end
        end
        pa = run_drum;

        if (run_drum_b && !pb) dr_b = cyc;
        if (!run_drum_b && pb) begin
            if (exp_drum_b.size() == 0) chk("drum_b_extra", exp_drum_b.size(), 1);
            else begin
                g = exp_drum_b.pop_front();
                chk("drum_b_len", cyc - dr_b, g);
            end
        end
        pb = run_drum_b;

        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic wr(input int addr, input logic [15:0] data);
        @(posedge clk); #1;
        wr_en = 1'b1;
        wr_addr = IDX_W'(addr);
        wr_data = data;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Pulses start and returns the number of edges until a note is seen.
    task automatic start_play(output int lat);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = 1;
        while (notes == 0 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) chk("idle_timeout", int'(busy), 0);
    endtask

    task automatic finish_test(input string tag, input int d0, input int ndone);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_done"}, done_cnt - d0, ndone);
        chk({tag, "_idx"}, int'(idx), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_noteq"}, exp_note.size(), 0);
        chk({tag, "_gapq"}, exp_gap.size(), 0);
        chk({tag, "_drumq"}, exp_drum_a.size() + exp_drum_b.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int d0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_notes", int'(notes), 0);
        chk("rst_drum", int'(run_drum), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_idx", int'(idx), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_vol", int'(vol), 0);
        chk("rst_octave", int'(octave), 0);
        rst_n = 1'b1;

        // Test 1: C dur2, D+drum+octave dur1, E+drum_var+end dur1, no loop
        wr(0, 16'h0201); wr(1, 16'h0132); wr(2, 16'h01C4);
        push_note(1, 2 * UNIT); exp_gap.push_back(LOW_GAP);
        push_note(2, UNIT);     exp_gap.push_back(LOW_GAP);
        push_note(4, UNIT);
        exp_drum_a.push_back(DRUM_A);
        exp_drum_b.push_back(DRUM_B);
        d0 = done_cnt;
        start_play(lat);
        chk("t1_latency", lat, 2);
        repeat (25) @(posedge clk);
        #1;
        chk("t1_idx_step1", int'(idx), 1);
        chk("t1_busy", int'(busy), 1);
        chk("t1_octave", int'(octave), 1);
        chk("t1_drum_on", int'(run_drum), 1);
        repeat (10) @(posedge clk);
        #1;
        chk("t1_release_notes", int'(notes), 0);
        chk("t1_release_octave", int'(octave), 1);
        repeat (5) @(posedge clk);
        #1;
        chk("t1_e_notes", int'(notes), 4);
        chk("t1_e_dvar", int'(dvar), 1);
        chk("t1_e_octave", int'(octave), 0);
        wait_idle(200);
        finish_test("t1", d0, 1);
        chk("t1_final_gap", done_cyc - fall_cyc, GAP);

        // Test 2: same pattern looping, stopped during the release after the wrapped C
        loop_en = 1'b1;
        push_note(1, 2 * UNIT); exp_gap.push_back(LOW_GAP);
        push_note(2, UNIT);     exp_gap.push_back(LOW_GAP);
        push_note(4, UNIT);     exp_gap.push_back(LOW_GAP);
        push_note(1, 2 * UNIT);
        exp_drum_a.push_back(DRUM_A);
        exp_drum_b.push_back(DRUM_B);
        d0 = done_cnt;
        start_play(lat);
        repeat (50) @(posedge clk);
        #1;
        chk("t2_wrap_idx", int'(idx), 0);
        chk("t2_wrap_note", int'(notes), 1);
        repeat (19) @(posedge clk);
        #1;
        chk("t2_still_busy", int'(busy), 1);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        loop_en = 1'b0;
        finish_test("t2", d0, 0);

        // Test 3: stop and start together during step 1
        push_note(1, 2 * UNIT); exp_gap.push_back(LOW_GAP);
        push_note(2, 2);
        exp_drum_a.push_back(2);
        exp_drum_b.push_back(2);
        d0 = done_cnt;
        start_play(lat);
        repeat (24) @(posedge clk);
        #1;
        stop = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        start = 1'b0;
        chk("t3_busy", int'(busy), 0);
        chk("t3_notes", int'(notes), 0);
        chk("t3_drum", int'(run_drum), 0);
        chk("t3_drum_b", int'(run_drum_b), 0);
        chk("t3_idx", int'(idx), 0);
        finish_test("t3", d0, 0);

        // Test 4: dur 0 drum step; the long drum pulse runs into the next step
        wr(0, 16'h0018); wr(1, 16'h0181);
        push_note(8, UNIT); exp_gap.push_back(LOW_GAP);
        push_note(1, UNIT);
        exp_drum_a.push_back(DRUM_A);
        exp_drum_b.push_back(DRUM_B);
        d0 = done_cnt;
        start_play(lat);
        repeat (14) @(posedge clk);
        #1;
        chk("t4_next_note", int'(notes), 1);
        chk("t4_drum_b_carry", int'(run_drum_b), 1);
        wait_idle(200);
        finish_test("t4", d0, 1);

        // Test 4b: full table without end bit, mid-play rewrite and stray start
        for (int i = 0; i < STEPS; i++) begin
            wr(i, 16'h0100 | 16'(1 << (i % 4)));
            push_note(1 << (i % 4), UNIT);
            if (i > 0) exp_gap.push_back(LOW_GAP);
        end
        d0 = done_cnt;
        start_play(lat);
        wr(0, 16'h0308);
        repeat (99) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (98) @(posedge clk);
        #1;
        chk("t4b_last_idx", int'(idx), STEPS - 1);
        wait_idle(400);
        finish_test("t4b", d0, 1);

        // Test 5: asynchronous reset during PLAY, then the cleared table plays silently
        wr(0, 16'h0201);
        push_note(1, 5);
        start_play(lat);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_notes", int'(notes), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_drum", int'(run_drum), 0);
        chk("t5_vol", int'(vol), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        d0 = done_cnt;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("t5_busy_after_start", int'(busy), 1);
        repeat (20) @(posedge clk);
        #1;
        chk("t5_empty_idx", int'(idx), 1);
        chk("t5_empty_notes", int'(notes), 0);
        wait_idle(400);
        finish_test("t5", d0, 1);

        // Test 6: volume
        @(posedge clk); #1 vol_target = 8'd200;
`ifdef VOLUME_FADE_EN
        repeat (605) @(posedge clk);
        #1;
        chk("t6_fade_up", int'(vol), 200);
        vol_target = 8'd190;
        repeat (40) @(posedge clk);
        #1;
        chk("t6_fade_down", int'(vol), 190);
`else
        #1;
        chk("t6_vol_before_edge", int'(vol), 0);
        @(posedge clk); #1;
        chk("t6_vol_after_edge", int'(vol), 200);
        vol_target = 8'd190;
        @(posedge clk); #1;
        chk("t6_vol_track", int'(vol), 190);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
